// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control FSM: states, opcodes,
// ImmSel codes, datapath mux selects and the per-state control word.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
  } iclass_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BR     = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // pc_jump: unconditional PC load in EXEC; pc_br: PC load qualified by br_taken.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_src;
    logic       pc_jump;
    logic       pc_br;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       busy;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic ctrl_t ctrl_for(state_t s, iclass_t c);
    ctrl_t o;
    o = CTRL_IDLE;
    case (s)
      S_FETCH: begin
        o.mem_req   = 1'b1;
        o.alu_src_a = SRCA_PC;
        o.alu_src_b = SRCB_FOUR;
        o.alu_op    = ALU_ADD;
        o.busy      = 1'b1;
      end
      S_DECODE: begin
        o.alu_src_a = SRCA_OLDPC;
        o.alu_src_b = SRCB_IMM;
        o.alu_op    = ALU_ADD;
        o.busy      = 1'b1;
      end
      S_EXEC: begin
        o.busy = 1'b1;
        case (c)
          C_OP: begin
            o.alu_src_a = SRCA_RS1;
            o.alu_src_b = SRCB_RS2;
            o.alu_op    = ALU_FUNCT;
          end
          C_OPIMM: begin
            o.alu_src_a = SRCA_RS1;
            o.alu_src_b = SRCB_IMM;
            o.alu_op    = ALU_FUNCT;
          end
          C_LOAD, C_STORE, C_LUI: begin
            o.alu_src_a = SRCA_RS1;
            o.alu_src_b = SRCB_IMM;
          end
          C_BRANCH: begin
            o.alu_src_a  = SRCA_RS1;
            o.alu_src_b  = SRCB_RS2;
            o.alu_op     = ALU_BR;
            o.pc_br      = 1'b1;
            o.result_src = RES_ALUOUT;
          end
          C_JAL: begin
            // PC takes the DECODE target while old PC + 4 lands in the result register
            o.alu_src_a  = SRCA_OLDPC;
            o.alu_src_b  = SRCB_FOUR;
            o.pc_jump    = 1'b1;
            o.result_src = RES_ALUOUT;
          end
          C_JALR: begin
            o.alu_src_a  = SRCA_RS1;
            o.alu_src_b  = SRCB_IMM;
            o.pc_jump    = 1'b1;
            o.result_src = RES_ALU;
          end
          C_AUIPC: begin
            o.alu_src_a = SRCA_OLDPC;
            o.alu_src_b = SRCB_IMM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        o.mem_req  = 1'b1;
        o.addr_src = 1'b1;
        o.mem_we   = (c == C_STORE);
        o.busy     = 1'b1;
      end
      S_WB: begin
        o.reg_write  = 1'b1;
        o.result_src = (c == C_LOAD) ? RES_MEM : RES_ALUOUT;
        o.busy       = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/imm_sel_decode.sv
// Opcode -> ImmSel, instruction class and legality. Purely combinational.
module imm_sel_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_sel,
  output iclass_t    iclass,
  output logic       legal
);

  always_comb begin
    imm_sel = IMM_NONE;
    iclass  = C_ILL;
    legal   = 1'b1;
    case (opcode)
      OPC_OPIMM:  begin imm_sel = IMM_I;    iclass = C_OPIMM;  end
      OPC_LOAD:   begin imm_sel = IMM_I;    iclass = C_LOAD;   end
      OPC_JALR:   begin imm_sel = IMM_I;    iclass = C_JALR;   end
      OPC_STORE:  begin imm_sel = IMM_S;    iclass = C_STORE;  end
      OPC_BRANCH: begin imm_sel = IMM_B;    iclass = C_BRANCH; end
      OPC_LUI:    begin imm_sel = IMM_U;    iclass = C_LUI;    end
      OPC_AUIPC:  begin imm_sel = IMM_U;    iclass = C_AUIPC;  end
      OPC_JAL:    begin imm_sel = IMM_J;    iclass = C_JAL;    end
      OPC_OP:     begin imm_sel = IMM_NONE; iclass = C_OP;     end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB, sticky illegal HALT).
// Define INSTRET_CNT_EN to add the retired-instruction counter output instret_cnt.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OPC_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic [2:0]       funct3,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [2:0]       ImmSel,
  output logic             illegal,
  output logic             busy
`ifdef INSTRET_CNT_EN
  ,
  output logic [XLEN-1:0]  instret_cnt
`endif
);

  state_t     state, state_n;
  iclass_t    cls_q, cls_n, dec_cls;
  logic [2:0] imm_q, dec_imm;
  logic       dec_legal;
  ctrl_t      ctl;

  // funct3 is decoded by the ALU control, not by the sequencer
  logic [2:0] unused_funct3;
  assign unused_funct3 = funct3;

  imm_sel_decode u_dec (
    .opcode  (opcode),
    .imm_sel (dec_imm),
    .iclass  (dec_cls),
    .legal   (dec_legal)
  );

  always_comb begin
    state_n = state;
    cls_n   = cls_q;
    case (state)
      S_IDLE:   state_n = S_FETCH;
      S_FETCH:  if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        cls_n   = dec_cls;
        state_n = dec_legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE: state_n = S_MEM;
          C_BRANCH:        state_n = S_FETCH;
          default:         state_n = S_WB;
        endcase
      end
      S_MEM:    if (mem_ready) state_n = (cls_q == C_STORE) ? S_FETCH : S_WB;
      S_WB:     state_n = S_FETCH;
      default:  state_n = S_HALT;
    endcase
  end

  // Control word is registered against the next state, so outputs are glitch-free
  // Moore outputs of the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cls_q   <= C_ILL;
      imm_q   <= IMM_NONE;
      ctl     <= CTRL_IDLE;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      cls_q <= cls_n;
      ctl   <= ctrl_for(state_n, cls_n);
      if (state == S_DECODE) begin
        imm_q <= dec_imm;
        if (!dec_legal) illegal <= 1'b1;
      end else if (state_n == S_FETCH) begin
        imm_q <= IMM_NONE;
      end
    end
  end

  // IR is only loaded at the end of FETCH, so DECODE must see ImmSel live from opcode.
  assign ImmSel     = (state == S_DECODE) ? dec_imm : imm_q;
  assign ir_write   = (state == S_FETCH) && mem_ready;
  assign pc_write   = ir_write || ctl.pc_jump || (ctl.pc_br && br_taken);
  assign mem_req    = ctl.mem_req;
  assign mem_we     = ctl.mem_we;
  assign addr_src   = ctl.addr_src;
  assign reg_write  = ctl.reg_write;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign result_src = ctl.result_src;
  assign busy       = ctl.busy;

`ifdef INSTRET_CNT_EN
  logic retire;
  assign retire = (state == S_WB)
               || (state == S_EXEC && cls_q == C_BRANCH)
               || (state == S_MEM  && cls_q == C_STORE && mem_ready);

  always_ff @(posedge clk) begin
    if (!rst_n)      instret_cnt <= '0;
    else if (retire) instret_cnt <= instret_cnt + XLEN'(1);
  end
`else
  logic [XLEN-1:0] unused_xlen;
  assign unused_xlen = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized self-checking bench: each instruction is planned as a list of phases
// with memory waits, and every cycle's outputs are compared to the phase table.
module tb_multicycle_ctrl_fsm;

  localparam int P_IDLE = 0, P_F = 1, P_D = 2, P_E = 3, P_M = 4, P_W = 5, P_H = 6;

  localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JAL = 7'b1101111,
                         O_JALR = 7'b1100111, O_BR = 7'b1100011, O_LD = 7'b0000011,
                         O_ST = 7'b0100011, O_OPI = 7'b0010011, O_OP = 7'b0110011,
                         O_BAD = 7'b1111111;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic br_taken = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, addr_src, ir_write, pc_write, reg_write, illegal, busy;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] ImmSel;
`ifdef INSTRET_CNT_EN
  logic [31:0] instret_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int icnt = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.XLEN(32), .OPC_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .ImmSel(ImmSel), .illegal(illegal), .busy(busy)
`ifdef INSTRET_CNT_EN
    , .instret_cnt(instret_cnt)
`endif
  );

  logic [18:0] obs;
  assign obs = {mem_req, mem_we, addr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, ImmSel, illegal, busy};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] opc);
    case (opc)
      O_OPI, O_LD, O_JALR: return 3'b000;
      O_ST:                return 3'b001;
      O_BR:                return 3'b010;
      O_LUI, O_AUIPC:      return 3'b011;
      O_JAL:               return 3'b100;
      default:             return 3'b111;
    endcase
  endfunction

  function automatic logic [18:0] exp_out(input int ph, input logic [6:0] opc,
                                          input logic tk, input logic rdy);
    logic mreq, we, as, irw, pcw, rw, ill, bsy;
    logic [1:0] a, b, op, rs;
    logic [2:0] imm;
    {mreq, we, as, irw, pcw, rw, ill} = '0;
    {a, b, op, rs} = '0;
    imm = 3'b111;
    bsy = !(ph == P_IDLE || ph == P_H);
    case (ph)
      P_H: ill = 1'b1;
      P_F: begin mreq = 1'b1; b = 2'b10; irw = rdy; pcw = rdy; end
      P_D: begin a = 2'b10; b = 2'b01; imm = imm_of(opc); end
      P_E: begin
        imm = imm_of(opc);
        case (opc)
          O_OP:         begin a = 2'b01; b = 2'b00; op = 2'b10; end
          O_OPI:        begin a = 2'b01; b = 2'b01; op = 2'b10; end
          O_LD, O_ST, O_LUI: begin a = 2'b01; b = 2'b01; end
          O_BR:         begin a = 2'b01; b = 2'b00; op = 2'b01; pcw = tk; end
          O_JAL:        begin a = 2'b10; b = 2'b10; pcw = 1'b1; end
          O_JALR:       begin a = 2'b01; b = 2'b01; pcw = 1'b1; rs = 2'b10; end
          O_AUIPC:      begin a = 2'b10; b = 2'b01; end
          default: ;
        endcase
      end
      P_M: begin mreq = 1'b1; as = 1'b1; we = (opc == O_ST); imm = imm_of(opc); end
      P_W: begin rw = 1'b1; rs = (opc == O_LD) ? 2'b01 : 2'b00; imm = imm_of(opc); end
      default: ;
    endcase
    return {mreq, we, as, irw, pcw, rw, a, b, op, rs, imm, ill, bsy};
  endfunction

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      opcode    = 7'($urandom);
      #1 chk("reset_idle", 32'(obs), 32'(exp_out(P_IDLE, 7'd0, 1'b0, 1'b0)));
    end
    rst_n = 1'b1;
    icnt  = 0;
    #1 chk("release_idle", 32'(obs), 32'(exp_out(P_IDLE, 7'd0, 1'b0, 1'b0)));
  endtask

  // Plans one instruction as a phase list; abort_idx >= 0 resets the DUT after that cycle.
  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw,
                           input logic tk, input int abort_idx);
    int   ph[$];
    logic rd[$];
    logic legal;
    legal = (opc inside {O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_OPI, O_OP});
    repeat (fw) begin ph.push_back(P_F); rd.push_back(1'b0); end
    ph.push_back(P_F); rd.push_back(1'b1);
    ph.push_back(P_D); rd.push_back(1'b0);
    if (legal) begin
      ph.push_back(P_E); rd.push_back(1'b0);
      if (opc == O_LD || opc == O_ST) begin
        repeat (mw) begin ph.push_back(P_M); rd.push_back(1'b0); end
        ph.push_back(P_M); rd.push_back(1'b1);
      end
      if (opc != O_ST && opc != O_BR) begin ph.push_back(P_W); rd.push_back(1'b0); end
    end else begin
      repeat (20) begin ph.push_back(P_H); rd.push_back(1'b0); end
    end
    for (int i = 0; i < ph.size(); i++) begin
      @(negedge clk);
      opcode    = (ph[i] == P_F) ? 7'($urandom) : opc;
      funct3    = 3'($urandom);
      mem_ready = (ph[i] == P_F || ph[i] == P_M) ? rd[i] : 1'($urandom);
      br_taken  = (ph[i] == P_E) ? tk : 1'($urandom);
      #1 chk($sformatf("opc%b_cyc%0d_ph%0d", opc, i, ph[i]), 32'(obs),
             32'(exp_out(ph[i], opc, tk, mem_ready)));
`ifdef INSTRET_CNT_EN
      if (i == 0) chk("instret", instret_cnt, 32'(icnt));
`endif
      if (i == abort_idx) begin
        rst_n = 1'b0;
        @(negedge clk);
        #1 chk("abort_idle", 32'(obs), 32'(exp_out(P_IDLE, 7'd0, 1'b0, 1'b0)));
        rst_n = 1'b1;
        icnt  = 0;
        return;
      end
    end
    if (legal) icnt++;
  endtask

  logic [6:0] ops [9] = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_OPI, O_OP};

  initial begin
    do_reset(3);
    run_instr(O_OP, 0, 0, 1'b0, -1);
    run_instr(O_LD, 2, 1, 1'b0, -1);
    run_instr(O_ST, 0, 0, 1'b0, -1);
    run_instr(O_BR, 0, 0, 1'b0, -1);
    run_instr(O_BR, 1, 0, 1'b1, -1);
    for (int i = 0; i < 9; i++) run_instr(ops[i], 0, 1, 1'b1, -1);
    // abort a load while it waits in MEM (plan index 3 = first MEM wait cycle)
    run_instr(O_LD, 0, 3, 1'b0, 3);
    for (int i = 0; i < 10; i++) run_instr(O_OP, i % 3, 0, 1'b0, -1);
    for (int i = 0; i < 150; i++)
      run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), -1);
    run_instr(O_BAD, 1, 0, 1'b0, -1);
    do_reset(2);
    run_instr(O_OP, 0, 0, 1'b0, -1);
    run_instr(O_JAL, 0, 0, 1'b0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Moore control FSM that sequences the datapath as a multi-cycle RISC-V core.
- Datapath pieces it drives: shared ALU, register file, immediate generator (drives ImmSel), and a single unified instruction/data memory port with a req/ready handshake.
- Decodes the opcode held in the instruction register and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Reports illegal opcodes and halts.

Parameters:
- XLEN, 32, datapath width; used only for instret_cnt width.
- OPC_W, 7, opcode field width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- opcode  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- br_taken  in  1  branch comparison result from the ALU, valid in EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- addr_src  out  1  0 = PC, 1 = ALU result register.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC update.
- reg_write  out  1  register-file write.
- alu_src_a  out  2  00 = PC, 01 = rs1, 10 = old PC.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- result_src  out  2  00 = ALU result register, 01 = mem data, 10 = ALU output.
- ImmSel  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J, 111 = none.
- illegal  out  1  illegal opcode, sticky.
- busy  out  1  high when not in IDLE/HALT.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. State register updated on posedge clk only.
- Reset:
  - rst_n low at posedge: state <= IDLE, illegal <= 0.
  - All outputs 0 except ImmSel = 111 in IDLE.
  - IDLE -> FETCH unconditionally on the next edge.
  - Reset mid-instruction abandons it; mem_req drops to 0 the cycle after the reset edge.
- FETCH:
  - Drives mem_req = 1, addr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00.
  - Holds until mem_ready = 1.
  - In the ready cycle: ir_write = 1, pc_write = 1 (PC <= PC+4), next state DECODE.
  - mem_req stays high and stable while waiting.
- DECODE:
  - ImmSel from opcode: 0010011/0000011/1100111 -> 000; 0100011 -> 001; 1100011 -> 010; 0110111/0010111 -> 011; 1101111 -> 100; 0110011 -> 111.
  - Precomputes old PC + imm: alu_src_a = 10, alu_src_b = 01, alu_op = 00.
  - Any other opcode -> HALT, illegal <= 1.
- EXEC:
  - R/I-ALU: alu_src_a = 01, alu_op = 10; alu_src_b = 00 for R, 01 for I. Next WB.
  - LOAD/STORE: address = rs1 + imm. Next MEM.
  - BRANCH: alu_op = 01; pc_write = br_taken with result_src = 00 (target from DECODE). Next FETCH.
  - JAL: alu_src_a = 10, alu_src_b = 10 (old PC + 4 into the ALU result register); pc_write = 1 with result_src = 00. Next WB.
  - JALR: pc_write = 1, result_src = 10, target = rs1 + imm. Next WB.
  - LUI: imm passthrough with rs1 forced to x0 by the datapath. AUIPC: uses the DECODE result. Both go to WB.
  - ImmSel holds its DECODE value through EXEC/MEM/WB.
- MEM:
  - mem_req = 1, addr_src = 1, mem_we = 1 for a store.
  - Waits for mem_ready.
  - Store -> FETCH; load -> WB.
- WB:
  - reg_write = 1 for one cycle; result_src = 01 for a load, else 00. Next FETCH.
- Latency with zero-wait memory:
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles. Load: 5. Store: 4. Branch: 3.
  - Each memory wait cycle adds 1.
- Rules:
  - mem_ready is ignored outside FETCH/MEM.
  - mem_req and reg_write are never high in the same cycle.
- HALT: all strobes 0, busy = 0, illegal = 1; exits only on reset.

Optional Feature:
- Macro INSTRET_CNT_EN.
- When defined:
  - Adds output instret_cnt [XLEN-1:0], cleared by reset.
  - Increments by 1 on each instruction's final cycle (WB, branch EXEC, store MEM with mem_ready); wraps from 2^XLEN-1 to 0.
  - Does not increment for the illegal instruction.
- When undefined: port and logic are absent; behaviour otherwise identical.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum;
  - opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP);
  - ImmSel codes (IMM_I = 000 ... IMM_NONE = 111);
  - alu_op/src encodings.
- Sub-module imm_sel_decode: combinational opcode -> ImmSel plus legal flag, reused by the FSM.

Test Plan:
- Reset held 3 cycles, release, mem_ready = 1, opcode 0110011 -> IDLE, FETCH, DECODE(ImmSel = 111), EXEC, WB(reg_write = 1), FETCH again 4 cycles after the first FETCH.
- LOAD 0000011 with mem_ready low 2 cycles in FETCH and 1 cycle in MEM -> mem_req stable high while waiting; ImmSel = 000; reg_write with result_src = 01 at cycle 8.
- STORE 0100011 -> ImmSel = 001, mem_we = 1 only in MEM, no reg_write, back to FETCH.
- BRANCH 1100011 with br_taken = 0 then 1 -> ImmSel = 010; pc_write 0 then 1 in EXEC; 3-cycle instruction.
- Opcode 1111111 -> DECODE -> HALT; illegal = 1 and busy = 0 persist 20 cycles; rst_n low clears them.
- rst_n low during MEM wait -> next state IDLE, mem_req = 0; with INSTRET_CNT_EN, 10 R-type instructions give instret_cnt = 10, and the aborted one is not counted.
